inst_encode: RTL and testbench
==============================

INST_ENCODE -- requirements
Module: inst_encode

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, width of the instruction-memory word address.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, number of output buffer entries (power of two, >=2).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, one-cycle pulse that begins a load session.
REQ-006 SHALL have port base_addr, input, ADDR_W, first write address, sampled on start.
REQ-007 SHALL have ports req_valid (input, 1) and req_ready (output, 1), the request handshake.
REQ-008 SHALL have ports req_op (input, 3) for ADD/SUB/OR/AND/ADDI/LW/SW/BEQ, and req_last (input, 1) to mark the final request.
REQ-009 SHALL have ports req_rd, req_rs1, req_rs2 (input, 5 each), register indices.
REQ-010 SHALL have port req_imm, input, 32, signed immediate (byte offset for BEQ).
REQ-011 SHALL have ports wr_valid (output, 1), wr_ready (input, 1), wr_addr (output, ADDR_W) and wr_data (output, 32), the instruction-memory write handshake.
REQ-012 SHALL have ports busy (output, 1), done (output, 1, one-cycle pulse), err (output, 1, sticky) and err_cnt (output, 8, saturating).

Function
REQ-013 SHALL implement FSM IDLE -> RUN on start; RUN -> DRAIN when a req_last request is accepted; DRAIN -> DONE when the FIFO is empty; DONE -> IDLE after one cycle.
REQ-014 SHALL assert done only in DONE, and busy in RUN, DRAIN and DONE.
REQ-015 SHALL ignore start outside IDLE.
REQ-016 SHALL drive req_ready=1 only in RUN with the FIFO not full; a transfer occurs when req_valid and req_ready are both 1.
REQ-017 SHALL encode each accepted request combinationally and write it into the FIFO in the same cycle, so the word is visible on wr_data at the earliest one cycle later.
REQ-018 SHALL encode R-type as {funct7, rs2, rs1, funct3, rd, 0110011}: funct7=0100000 for SUB, 0 otherwise; funct3 000 for ADD/SUB, 110 for OR, 111 for AND.
REQ-019 SHALL encode ADDI as imm[11:0], rs1, 000, rd, 0010011, and LW the same with funct3 010 and opcode 0000011.
REQ-020 SHALL encode SW as imm[11:5], rs2, rs1, 010, imm[4:0], 0100011.
REQ-021 SHALL encode BEQ as imm[12], imm[10:5], rs2, rs1, 000, imm[4:1], imm[11], 1100011.
REQ-022 SHALL flag a request as illegal when any of these holds: op is undefined; an I/S immediate is outside -2048..2047; a BEQ immediate is outside -4096..4094; a BEQ immediate is odd.
REQ-023 SHALL replace an illegal request's word with 0x00000013 (NOP), set err, and increment err_cnt, saturating at 255.
REQ-024 SHALL drive wr_valid=1 whenever the FIFO is non-empty, with wr_data taken from the FIFO head.
REQ-025 SHALL increment wr_addr by 1 on each wr_valid and wr_ready transfer, wrapping from 2^ADDR_W-1 to 0.
REQ-026 SHALL allow a push and a pop in the same cycle when the FIFO is full, with occupancy unchanged; req_ready still reflects the registered full flag.
REQ-027 SHALL hold wr_data and wr_addr stable while wr_valid=1 and wr_ready=0.
REQ-028 SHALL clear err and err_cnt on start.

Reset
REQ-029 SHALL, on rst_n low, asynchronously enter IDLE, empty the FIFO and clear req_ready, wr_valid, busy, done, err, err_cnt and wr_addr to 0.
REQ-030 SHALL discard FIFO contents on a reset asserted mid-session, with no write issued after reset.

Structure
REQ-031 SHALL take the opcode constants (B, I, II, R, S), the funct3/funct7 values, the op enum and the NOP word from the shared def package.
REQ-032 SHALL place the FIFO in a sub-module named enc_fifo, parameterised by width and depth.

Verification
REQ-033 SHALL verify that base_addr=0x010 with ADD rd=3 rs1=1 rs2=2 gives a write to addr 0x010 with data 0x002081B3.
REQ-034 SHALL verify that SUB x5,x6,x7, then LW x1,8(x2), then SW x3,4(x2) give 0x407302B3, 0x00812083 and 0x00312223 at consecutive addresses.
REQ-035 SHALL verify that BEQ x1,x2,imm=-4 gives 0xFE208EE3, and that imm=-3 gives 0x00000013 with err=1 and err_cnt=1.
REQ-036 SHALL verify that ADDI with imm=2048 gives a NOP with err set, while imm=-2048 gives 0x80000093-form output with rd=1 and rs1=0.
REQ-037 SHALL verify that wr_ready held at 0 for 5 cycles makes req_ready drop after 2 accepts, wr_data stays stable, and all words emerge in order once wr_ready=1.
REQ-038 SHALL verify that base_addr=0x3FF with 2 requests writes to 0x3FF then 0x000, and that req_last drives done high for one cycle followed by IDLE.

Source files
------------

// File: rtl/inst_encode_pkg.sv
// Shared definitions for the instruction encoder: opcodes, function codes,
// the request op enum, the NOP word and the combinational encoder function.
package inst_encode_pkg;

   typedef enum logic [2:0] {
      OP_ADD  = 3'd0,
      OP_SUB  = 3'd1,
      OP_OR   = 3'd2,
      OP_AND  = 3'd3,
      OP_ADDI = 3'd4,
      OP_LW   = 3'd5,
      OP_SW   = 3'd6,
      OP_BEQ  = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   localparam logic [6:0] OPC_R  = 7'b0110011;
   localparam logic [6:0] OPC_II = 7'b0010011;
   localparam logic [6:0] OPC_I  = 7'b0000011;
   localparam logic [6:0] OPC_S  = 7'b0100011;
   localparam logic [6:0] OPC_B  = 7'b1100011;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_OR  = 3'b110;
   localparam logic [2:0] F3_AND = 3'b111;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_SW  = 3'b010;
   localparam logic [2:0] F3_BEQ = 3'b000;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_SUB  = 7'b0100000;

   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

   typedef struct packed {
      logic        illegal;
      logic [31:0] word;
   } enc_result_t;

   // 12-bit signed range -2048..2047: all bits above bit 11 replicate the sign
   function automatic logic imm12_ok(input logic [31:0] imm);
      return imm[31:11] == {21{imm[31]}};
   endfunction

   // Branch offsets are 13-bit signed and must be even
   function automatic logic immb_ok(input logic [31:0] imm);
      return (imm[31:12] == {20{imm[31]}}) && !imm[0];
   endfunction

   function automatic enc_result_t encode(
      input logic [2:0]  op,
      input logic [4:0]  rd,
      input logic [4:0]  rs1,
      input logic [4:0]  rs2,
      input logic [31:0] imm
   );
      enc_result_t r;
      r.illegal = 1'b0;
      r.word    = NOP_WORD;
      case (op_e'(op))
         OP_ADD:  r.word = {F7_BASE, rs2, rs1, F3_ADD, rd, OPC_R};
         OP_SUB:  r.word = {F7_SUB,  rs2, rs1, F3_ADD, rd, OPC_R};
         OP_OR:   r.word = {F7_BASE, rs2, rs1, F3_OR,  rd, OPC_R};
         OP_AND:  r.word = {F7_BASE, rs2, rs1, F3_AND, rd, OPC_R};
         OP_ADDI: begin
            r.word    = {imm[11:0], rs1, F3_ADD, rd, OPC_II};
            r.illegal = !imm12_ok(imm);
         end
         OP_LW: begin
            r.word    = {imm[11:0], rs1, F3_LW, rd, OPC_I};
            r.illegal = !imm12_ok(imm);
         end
         OP_SW: begin
            r.word    = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OPC_S};
            r.illegal = !imm12_ok(imm);
         end
         OP_BEQ: begin
            r.word    = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OPC_B};
            r.illegal = !immb_ok(imm);
         end
         default: r.illegal = 1'b1;
      endcase
      if (r.illegal) begin
         r.word = NOP_WORD;
      end
      return r;
   endfunction

endpackage

// File: rtl/enc_fifo.sv
// Small power-of-two FIFO holding encoded words until instruction memory accepts them.
// Full and empty are registered; a push while full is accepted only alongside a pop.
module enc_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] CNT_LAST = (AW + 1)'(DEPTH - 1);
   localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign do_pop    = pop && !empty;
   assign do_push   = push && (!full || do_pop);
   assign head_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10: begin
               count <= count + 1'b1;
               full  <= (count == CNT_LAST);
               empty <= 1'b0;
            end
            2'b01: begin
               count <= count - 1'b1;
               full  <= 1'b0;
               empty <= (count == CNT_ONE);
            end
            default: ;
         endcase
      end
   end

   // Storage needs no reset: entries are only read when empty is low
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/inst_encode.sv
// Turns a stream of symbolic instruction requests into RV32I words and writes
// them to consecutive instruction-memory addresses starting at base_addr.
module inst_encode
   import inst_encode_pkg::*;
#(
   parameter int ADDR_W     = 10,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_op,
   input  logic              req_last,
   input  logic [4:0]        req_rd,
   input  logic [4:0]        req_rs1,
   input  logic [4:0]        req_rs2,
   input  logic [31:0]       req_imm,
   output logic              wr_valid,
   input  logic              wr_ready,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [7:0]        err_cnt
);

   state_e      state;
   enc_result_t enc;
   logic        fifo_full;
   logic        fifo_empty;
   logic        accept;
   logic        wr_fire;
   logic        session_start;

   assign enc           = encode(req_op, req_rd, req_rs1, req_rs2, req_imm);
   assign req_ready     = (state == S_RUN) && !fifo_full;
   assign accept        = req_valid && req_ready;
   assign wr_valid      = !fifo_empty;
   assign wr_fire       = wr_valid && wr_ready;
   assign session_start = (state == S_IDLE) && start;

   enc_fifo #(
      .WIDTH (32),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (accept),
      .push_data (enc.word),
      .pop       (wr_fire),
      .head_data (wr_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Session sequencer with busy/done registered alongside the state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_RUN;
                  busy  <= 1'b1;
               end
            end
            S_RUN: begin
               if (accept && req_last) begin
                  state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (fifo_empty) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   // Error flag is sticky within a session; the counter saturates rather than wraps
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err     <= 1'b0;
         err_cnt <= '0;
      end else if (session_start) begin
         err     <= 1'b0;
         err_cnt <= '0;
      end else if (accept && enc.illegal) begin
         err <= 1'b1;
         if (err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_addr <= '0;
      end else if (session_start) begin
         wr_addr <= base_addr;
      end else if (wr_fire) begin
         wr_addr <= wr_addr + 1'b1;
      end
   end

endmodule

// File: tb/tb_inst_encode.sv
// Directed bench for inst_encode: requests push expected writes into a scoreboard
// that an independent monitor drains as the DUT presents instruction-memory writes.
module tb_inst_encode;
   import inst_encode_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [9:0]  base_addr;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic        req_last;
   logic [4:0]  req_rd;
   logic [4:0]  req_rs1;
   logic [4:0]  req_rs2;
   logic [31:0] req_imm;
   logic        wr_valid;
   logic        wr_ready;
   logic [9:0]  wr_addr;
   logic [31:0] wr_data;
   logic        busy;
   logic        done;
   logic        err;
   logic [7:0]  err_cnt;

   typedef struct {
      logic [9:0]  addr;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   logic [9:0]  exp_addr;
   int          checks;
   int          errors;
   logic        stalled;
   logic [9:0]  hold_addr;
   logic [31:0] hold_data;

   inst_encode #(
      .ADDR_W     (10),
      .FIFO_DEPTH (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_last  (req_last),
      .req_rd    (req_rd),
      .req_rs1   (req_rs1),
      .req_rs2   (req_rs2),
      .req_imm   (req_imm),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .err_cnt   (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Entered and left at posedge+2; inputs stay valid until the DUT accepts
   task automatic apply_stimulus(input op_e op, input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [31:0] imm,
                                 input logic last, input logic [31:0] exp_word);
      bit got;
      exp_t e;
      req_valid = 1'b1;
      req_op    = op;
      req_rd    = rd;
      req_rs1   = rs1;
      req_rs2   = rs2;
      req_imm   = imm;
      req_last  = last;
      got       = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (req_ready) begin
            got = 1'b1;
            break;
         end
      end
      if (got) begin
         e.addr = exp_addr;
         e.data = exp_word;
         sb.push_back(e);
         exp_addr = exp_addr + 10'd1;
      end else begin
         checks++;
         errors++;
         $display("[TB] FAIL req_accept: op %0d never accepted within 50 cycles", op);
      end
      @(posedge clk);
      #2;
      req_valid = 1'b0;
      req_last  = 1'b0;
   endtask

   task automatic start_session(input logic [9:0] base);
      start     = 1'b1;
      base_addr = base;
      exp_addr  = base;
      @(posedge clk);
      #2;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      check_output({name, "_done_seen"}, {31'b0, seen}, 32'd1);
      if (seen) begin
         check_output({name, "_busy_in_done"}, {31'b0, busy}, 32'd1);
         @(negedge clk);
         check_output({name, "_done_pulse"}, {31'b0, done}, 32'd0);
         check_output({name, "_idle_busy"}, {31'b0, busy}, 32'd0);
      end
      check_output({name, "_sb_drained"}, sb.size(), 32'd0);
      @(posedge clk);
      #2;
   endtask

   // Monitor: pops on every write transfer and checks hold stability under stall
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         stalled = 1'b0;
      end else begin
         if (stalled && wr_valid) begin
            check_output("stall_addr_stable", {22'b0, wr_addr}, {22'b0, hold_addr});
            check_output("stall_data_stable", wr_data, hold_data);
         end
         if (wr_valid && wr_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_write: addr 0x%03h data 0x%08h with no expected entry",
                        wr_addr, wr_data);
            end else begin
               e = sb.pop_front();
               check_output("wr_addr", {22'b0, wr_addr}, {22'b0, e.addr});
               check_output("wr_data", wr_data, e.data);
            end
            stalled = 1'b0;
         end else if (wr_valid) begin
            stalled   = 1'b1;
            hold_addr = wr_addr;
            hold_data = wr_data;
         end else begin
            stalled = 1'b0;
         end
      end
   end

   initial begin
      bit any_valid;
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      start     = 1'b0;
      base_addr = '0;
      req_valid = 1'b0;
      req_op    = OP_ADD;
      req_last  = 1'b0;
      req_rd    = '0;
      req_rs1   = '0;
      req_rs2   = '0;
      req_imm   = '0;
      wr_ready  = 1'b1;
      exp_addr  = '0;

      repeat (2) @(negedge clk);
      check_output("rst_req_ready", {31'b0, req_ready}, 32'd0);
      check_output("rst_wr_valid", {31'b0, wr_valid}, 32'd0);
      check_output("rst_busy", {31'b0, busy}, 32'd0);
      check_output("rst_done", {31'b0, done}, 32'd0);
      check_output("rst_err", {31'b0, err}, 32'd0);
      check_output("rst_err_cnt", {24'b0, err_cnt}, 32'd0);
      check_output("rst_wr_addr", {22'b0, wr_addr}, 32'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #2;

      // Legal mix of every instruction format
      start_session(10'h010);
      apply_stimulus(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 32'h0020_81B3);
      apply_stimulus(OP_SUB, 5'd5, 5'd6, 5'd7, 32'd0, 1'b0, 32'h4073_02B3);
      apply_stimulus(OP_LW, 5'd1, 5'd2, 5'd0, 32'd8, 1'b0, 32'h0081_2083);
      apply_stimulus(OP_SW, 5'd0, 5'd2, 5'd3, 32'd4, 1'b0, 32'h0031_2223);
      apply_stimulus(OP_BEQ, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b0, 32'hFE20_8EE3);
      apply_stimulus(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800, 1'b1, 32'h8000_0093);
      wait_done("mix");
      check_output("mix_err", {31'b0, err}, 32'd0);
      check_output("mix_err_cnt", {24'b0, err_cnt}, 32'd0);

      // Odd branch offset
      start_session(10'h020);
      apply_stimulus(OP_BEQ, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFD, 1'b1, NOP_WORD);
      wait_done("beq_odd");
      check_output("beq_odd_err", {31'b0, err}, 32'd1);
      check_output("beq_odd_err_cnt", {24'b0, err_cnt}, 32'd1);

      // Out-of-range I immediate; err state from the last session must clear on start
      start_session(10'h030);
      @(negedge clk);
      check_output("start_clears_err", {31'b0, err}, 32'd0);
      check_output("start_clears_err_cnt", {24'b0, err_cnt}, 32'd0);
      @(posedge clk);
      #2;
      apply_stimulus(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, NOP_WORD);
      apply_stimulus(OP_OR, 5'd4, 5'd5, 5'd6, 32'd0, 1'b1, 32'h0062_E233);
      wait_done("addi_range");
      check_output("addi_range_err", {31'b0, err}, 32'd1);
      check_output("addi_range_err_cnt", {24'b0, err_cnt}, 32'd1);

      // Backpressure: two accepts fill the buffer, then nothing moves until wr_ready
      wr_ready = 1'b0;
      start_session(10'h040);
      apply_stimulus(OP_ADD, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 32'h0031_00B3);
      apply_stimulus(OP_AND, 5'd7, 5'd8, 5'd9, 32'd0, 1'b0, 32'h0094_73B3);
      @(negedge clk);
      check_output("bp_req_ready_full", {31'b0, req_ready}, 32'd0);
      check_output("bp_wr_valid", {31'b0, wr_valid}, 32'd1);
      repeat (3) @(negedge clk);
      check_output("bp_req_ready_hold", {31'b0, req_ready}, 32'd0);
      check_output("bp_head_addr", {22'b0, wr_addr}, 32'h040);
      check_output("bp_head_data", wr_data, 32'h0031_00B3);
      @(posedge clk);
      #2;
      wr_ready = 1'b1;
      apply_stimulus(OP_SUB, 5'd10, 5'd11, 5'd12, 32'd0, 1'b0, 32'h40C5_8533);
      apply_stimulus(OP_SW, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFF, 1'b1, 32'hFE20_AFA3);
      wait_done("bp");

      // Address wrap at the top of instruction memory
      start_session(10'h3FF);
      apply_stimulus(OP_ADDI, 5'd2, 5'd2, 5'd0, 32'd2047, 1'b0, 32'h7FF1_0113);
      apply_stimulus(OP_BEQ, 5'd0, 5'd3, 5'd4, 32'd8, 1'b1, 32'h0041_8463);
      wait_done("wrap");

      // Reset mid-session discards buffered words
      wr_ready = 1'b0;
      start_session(10'h100);
      apply_stimulus(OP_ADD, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0, 32'h0010_80B3);
      apply_stimulus(OP_ADD, 5'd2, 5'd2, 5'd2, 32'd0, 1'b0, 32'h0021_0133);
      @(negedge clk);
      rst_n = 1'b0;
      sb.delete();
      #1;
      check_output("midrst_wr_valid", {31'b0, wr_valid}, 32'd0);
      check_output("midrst_busy", {31'b0, busy}, 32'd0);
      check_output("midrst_wr_addr", {22'b0, wr_addr}, 32'd0);
      wr_ready = 1'b1;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      any_valid = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (wr_valid) any_valid = 1'b1;
      end
      check_output("midrst_no_write", {31'b0, any_valid}, 32'd0);
      check_output("midrst_idle", {31'b0, busy}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
